// File: rtl/bluetooth_tx.sv
`default_nettype none
// ============================================================================
// Module      : bluetooth_tx
// Description : Byte-oriented serial transmitter with a small transmit FIFO.
//               Each frame is a start bit (0), NBits data bits sent LSB first,
//               an optional even-parity bit and one stop bit (1).
//               Every bit lasts 16 oversampling ticks. One tick is BAUD_DIV
//               clock cycles.
//
//               Optional feature macro: BLUETOOTH_TX_PARITY_EN
//                 defined   -> a parity bit (even parity over the data bits
//                              actually sent) is inserted after DATA
//                 undefined -> frame is start + data + stop
//
// Parameters  : BAUD_DIV   - clock cycles per oversampling tick
//               FIFO_DEPTH - transmit FIFO entries (power of two)
//
// Ports       : Clk    in   system clock, rising edge
//               Rst    in   synchronous active-high reset
//               TxData in   [7:0] byte to queue
//               TxWr   in   write strobe (accepted only when Full=0)
//               NBits  in   [3:0] data bits per frame, latched at frame start
//               Tx     out  serial line, idles high
//               Full   out  FIFO holds FIFO_DEPTH entries
//               Busy   out  frame in flight or FIFO non-empty
//               TxDone out  one-cycle pulse after each stop bit
//
// Revision    : 1.0 - initial release
// ============================================================================
module bluetooth_tx #(
    parameter int BAUD_DIV   = 650,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [7:0] TxData,
    input  logic       TxWr,
    input  logic [3:0] NBits,
    output logic       Tx,
    output logic       Full,
    output logic       Busy,
    output logic       TxDone
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int c_PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W  = c_PTR_W + 1;

    localparam logic [c_BAUD_W-1:0] c_BAUD_MAX = c_BAUD_W'(BAUD_DIV - 1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_ONE = c_BAUD_W'(1);
    localparam logic [c_PTR_W-1:0]  c_PTR_MAX  = c_PTR_W'(FIFO_DEPTH - 1);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0]  c_CNT_FULL = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [3:0]          c_OS_LAST  = 4'd15;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
`ifdef BLUETOOTH_TX_PARITY_EN
    localparam logic [2:0] c_ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [2:0]          r_state;
    logic [2:0]          w_state_nx;

    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                w_full;
    logic                w_push;
    logic                w_pop;

    logic [c_BAUD_W-1:0] r_baud_cnt;
    logic                w_tick;
    logic [3:0]          r_os_cnt;
    logic                w_bit_end;

    logic [7:0]          r_shift;
    logic [2:0]          r_bit_cnt;
    logic [2:0]          r_last_bit;
    logic [2:0]          w_last_bit;
    logic                r_done;
`ifdef BLUETOOTH_TX_PARITY_EN
    logic                r_parity;
`endif
    logic                w_tx;
    logic                w_busy;

    // ------------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------------
    // Full comes from the registered count, so a write that meets a full FIFO
    // is dropped even if a pop frees an entry on the same edge.
    assign w_full = (r_count == c_CNT_FULL);
    assign w_push = TxWr && !w_full && !Rst;
    // Only IDLE consumes bytes; the popped byte goes straight to the shifter.
    assign w_pop  = (r_state == c_ST_IDLE) && (r_count != '0) && !Rst;

    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= TxData;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_MAX) ? '0 : r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_MAX) ? '0 : r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Bit timing: tick every BAUD_DIV cycles, bit end every 16 ticks.
    // Both counters restart on a pop so the start bit is exactly one bit long.
    // ------------------------------------------------------------------------
    assign w_tick    = (r_baud_cnt == c_BAUD_MAX);
    assign w_bit_end = w_tick && (r_os_cnt == c_OS_LAST);

    // Frame length is latched at pop; anything outside 5..8 sends a full byte.
    // NBits=8 gives NBits[2:0]-1 = 7 through the 3-bit wrap.
    assign w_last_bit = ((NBits >= 4'd5) && (NBits <= 4'd8)) ? 3'(NBits - 4'd1) : 3'd7;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_pop) begin
                    w_state_nx = c_ST_START;
                end
            end
            c_ST_START: begin
                if (w_bit_end) begin
                    w_state_nx = c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                if (w_bit_end && (r_bit_cnt == r_last_bit)) begin
`ifdef BLUETOOTH_TX_PARITY_EN
                    w_state_nx = c_ST_PARITY;
`else
                    w_state_nx = c_ST_STOP;
`endif
                end
            end
`ifdef BLUETOOTH_TX_PARITY_EN
            c_ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_nx = c_ST_STOP;
                end
            end
`endif
            c_ST_STOP: begin
                if (w_bit_end) begin
                    w_state_nx = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nx = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_tx = 1'b1;
        case (r_state)
            c_ST_START:  w_tx = 1'b0;
            c_ST_DATA:   w_tx = r_shift[0];
`ifdef BLUETOOTH_TX_PARITY_EN
            c_ST_PARITY: w_tx = r_parity;
`endif
            default:     w_tx = 1'b1;
        endcase
        w_busy = (r_state != c_ST_IDLE) || (r_count != '0);
    end

    assign Tx     = w_tx;
    assign Full   = w_full;
    assign Busy   = w_busy;
    assign TxDone = r_done;

    // ------------------------------------------------------------------------
    // Datapath: baud counters, shifter, bit counter, parity, done pulse
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_baud_cnt <= '0;
            r_os_cnt   <= '0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_last_bit <= 3'd7;
            r_done     <= 1'b0;
`ifdef BLUETOOTH_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;

            if (w_pop || w_tick) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + c_BAUD_ONE;
            end

            if (w_pop) begin
                r_os_cnt <= '0;
            end else if (w_tick) begin
                r_os_cnt <= r_os_cnt + 4'd1;
            end

            if (w_pop) begin
                r_shift    <= r_mem[r_rd_ptr];
                r_last_bit <= w_last_bit;
                r_bit_cnt  <= '0;
`ifdef BLUETOOTH_TX_PARITY_EN
                r_parity   <= 1'b0;
`endif
            end else if (w_bit_end) begin
                case (r_state)
                    c_ST_DATA: begin
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
`ifdef BLUETOOTH_TX_PARITY_EN
                        // Accumulate only bits that actually leave on the line.
                        r_parity  <= r_parity ^ r_shift[0];
`endif
                    end
                    c_ST_STOP: begin
                        // Lands in the first IDLE cycle, where the next pop
                        // can already happen for back-to-back frames.
                        r_done <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
